bp_mem_port_arbiter: RTL and testbench
======================================

// Module: bp_mem_port_arbiter
// PURPOSE
//  Shares one block-wide memory port (ready/valid cmd, valid/yumi resp) among num_req_p
//  memory transducers. Each cycle: picks one requester, forwards its cmd, records its ID
//  in an in-order tag FIFO. Routes each memory response back to the recorded requester.
//  Sits between the per-LCE/CCE mem transducers and the single DRAM/test-memory model.
// PARAMETERS
//  num_req_p          2    number of requesters (>=2)
//  paddr_width_p      40   physical address width
//  block_width_p      512  data width; mask width = block_width_p/8
//  max_outstanding_p  4    tag FIFO depth = max in-flight cmds (>=1)
// PORTS
//  clk_i          in   1                   clock
//  reset_i        in   1                   synchronous, active-high reset
//  req_v_i        in   num_req_p           per-requester cmd valid
//  req_w_i        in   num_req_p           per-requester write flag
//  req_addr_i     in   num_req_p*paddr     packed addresses, requester i at [i*paddr+:paddr]
//  req_data_i     in   num_req_p*block     packed write data
//  req_mask_i     in   num_req_p*block/8   packed byte write masks
//  req_ready_o    out  num_req_p           one-hot grant: cmd of requester i accepted this cycle
//  resp_v_o       out  num_req_p           one-hot response valid
//  resp_data_o    out  block               response data (shared by all requesters)
//  resp_yumi_i    in   num_req_p           per-requester response consume
//  mem_ready_i    in   1                   memory accepts cmd
//  mem_v_o        out  1                   cmd valid (= accepted; mem_v_o implies mem_ready_i)
//  mem_w_o        out  1                   cmd is write
//  mem_addr_o     out  paddr               cmd address
//  mem_data_o     out  block               cmd write data
//  mem_mask_o     out  block/8             cmd byte mask
//  mem_data_i     in   block               response data
//  mem_v_i        in   1                   response valid
//  mem_yumi_o     out  1                   response consumed
// BEHAVIOUR
//  - State: tag FIFO (max_outstanding_p x clog2(num_req_p)), occupancy count
//    0..max_outstanding_p, round-robin pointer last_r (index of last granted requester).
//  - Reset: count=0, FIFO ptrs=0, last_r=num_req_p-1 (req 0 highest priority first).
//    While reset_i=1: req_ready_o, resp_v_o, mem_v_o, mem_w_o, mem_yumi_o all 0.
//    Reset mid-operation drops all in-flight tags; memory must be reset in the same cycle.
//  - Grant (combinational, zero latency): can_issue = mem_ready_i & (count != max).
//    If can_issue, grant the first i with req_v_i[i], searching last_r+1, last_r+2, ...
//    with wrap modulo num_req_p. Grant drives req_ready_o[i]=1, mem_v_o=1; mux the
//    requester's w/addr/data/mask onto mem_*_o. No grant -> mem_v_o=0, mem_w_o=0.
//    On grant: push i into FIFO; last_r<=i at next edge.
//  - Every cmd (read or write) returns exactly one response, in issue order.
//  - Response: when mem_v_i=1 and count!=0, resp_v_o[head]=1, resp_data_o=mem_data_i,
//    mem_yumi_o=resp_yumi_i[head]. On mem_yumi_o: pop FIFO. resp_yumi_i for other
//    indices is ignored. resp_data_o passes mem_data_i through unconditionally.
//  - mem_v_i=1 with count==0: protocol error; resp_v_o=0, mem_yumi_o=0, simulation
//    $error (excluded from synthesis).
//  - Full: count==max blocks all grants, even if a pop occurs the same cycle (no bypass).
//  - Empty + push and pop same cycle cannot occur (pop needs count!=0).
//  - Simultaneous push and pop: count unchanged; both pointers advance, wrap at depth.
//  - Response cannot bypass the FIFO: a cmd granted in cycle t may respond no earlier
//    than t+1.
// CONFIGURATION
//  BP_MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index with req_v_i wins;
//    last_r unused and removed. Undefined (default): round-robin as above.
// TESTING
//  1. Reset, req_v_i=2'b11 both reads, mem_ready_i=1 held -> grants alternate
//     0,1,0,1 each cycle; mem_v_o=1 every cycle until FIFO full (4 grants).
//  2. Fill 4 cmds, no responses, req_v_i=2'b01 -> req_ready_o=0, mem_v_o=0; return one
//     response with yumi -> grant resumes next cycle, not same cycle.
//  3. Issue req1 write addr 0x8000_0040 mask all-ones, then req0 read 0x8000_0000;
//     responses D1, D2 -> resp_v_o=2'b10 with D1, then 2'b01 with D2.
//  4. mem_v_i=1, head=1, resp_yumi_i=2'b01 -> mem_yumi_o=0, FIFO unchanged;
//     resp_yumi_i=2'b10 -> pop.
//  5. Assert reset_i with 3 in flight -> next cycle count=0, all valids 0,
//     req 0 granted first afterwards.
//  6. With BP_MEM_ARB_FIXED_PRIO_EN, req_v_i=2'b11 held -> req 0 granted every cycle.

Source files
------------

// File: rtl/bp_mem_port_arbiter_if.sv
// ============================================================================
// Module      : bp_mem_port_arbiter_if
// Description : Requester-side and memory-side bundle of the shared memory port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface bp_mem_port_arbiter_if #(
    parameter int num_req_p     = 2,
    parameter int paddr_width_p = 40,
    parameter int block_width_p = 512
);
    logic [num_req_p-1:0]                   req_v_i;
    logic [num_req_p-1:0]                   req_w_i;
    logic [num_req_p*paddr_width_p-1:0]     req_addr_i;
    logic [num_req_p*block_width_p-1:0]     req_data_i;
    logic [num_req_p*block_width_p/8-1:0]   req_mask_i;
    logic [num_req_p-1:0]                   req_ready_o;
    logic [num_req_p-1:0]                   resp_v_o;
    logic [block_width_p-1:0]               resp_data_o;
    logic [num_req_p-1:0]                   resp_yumi_i;
    logic                                   mem_ready_i;
    logic                                   mem_v_o;
    logic                                   mem_w_o;
    logic [paddr_width_p-1:0]               mem_addr_o;
    logic [block_width_p-1:0]               mem_data_o;
    logic [block_width_p/8-1:0]             mem_mask_o;
    logic [block_width_p-1:0]               mem_data_i;
    logic                                   mem_v_i;
    logic                                   mem_yumi_o;

    modport slave (
        input  req_v_i, req_w_i, req_addr_i, req_data_i, req_mask_i, resp_yumi_i,
               mem_ready_i, mem_data_i, mem_v_i,
        output req_ready_o, resp_v_o, resp_data_o, mem_v_o, mem_w_o, mem_addr_o,
               mem_data_o, mem_mask_o, mem_yumi_o
    );

    modport master (
        output req_v_i, req_w_i, req_addr_i, req_data_i, req_mask_i, resp_yumi_i,
               mem_ready_i, mem_data_i, mem_v_i,
        input  req_ready_o, resp_v_o, resp_data_o, mem_v_o, mem_w_o, mem_addr_o,
               mem_data_o, mem_mask_o, mem_yumi_o
    );
endinterface

`default_nettype wire

// File: rtl/bp_mem_port_arbiter.sv
// ============================================================================
// Module      : bp_mem_port_arbiter
// Description : Shares one memory port among requesters; in-order tag FIFO routes
//               responses back. BP_MEM_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bp_mem_port_arbiter #(
    parameter int num_req_p         = 2,
    parameter int paddr_width_p     = 40,
    parameter int block_width_p     = 512,
    parameter int max_outstanding_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bp_mem_port_arbiter_if.slave  port_if
);
    localparam int idx_w_lp  = $clog2(num_req_p);
    localparam int ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w_lp  = $clog2(max_outstanding_p + 1);
    localparam int mask_w_lp = block_width_p / 8;

    logic [idx_w_lp-1:0] tags_q [max_outstanding_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                can_issue, grant_v, push, pop, resp_ok;
    logic [idx_w_lp-1:0] grant_idx, head;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO blocks grants even when a pop lands in the same cycle.
    assign can_issue = ~reset_i & port_if.mem_ready_i
                     & (count_q != cnt_w_lp'(max_outstanding_p));

`ifdef BP_MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (can_issue && port_if.req_v_i[k]) begin
                grant_v   = 1'b1;
                grant_idx = idx_w_lp'(k);
            end
        end
    end
`else
    logic [idx_w_lp-1:0] last_q;

    // Scan from the farthest candidate inward so the nearest one after last_q wins.
    always_comb begin
        int cand;
        cand      = 0;
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int k = num_req_p; k >= 1; k--) begin
            cand = (int'(last_q) + k) % num_req_p;
            if (can_issue && port_if.req_v_i[cand]) begin
                grant_v   = 1'b1;
                grant_idx = idx_w_lp'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= idx_w_lp'(num_req_p - 1);
        end else if (grant_v) begin
            last_q <= grant_idx;
        end
    end
`endif

    assign head    = tags_q[rd_ptr_q];
    assign resp_ok = ~reset_i & port_if.mem_v_i & (count_q != '0);
    assign push    = grant_v;
    assign pop     = port_if.mem_yumi_o;

    always_comb begin
        port_if.req_ready_o = '0;
        port_if.resp_v_o    = '0;
        if (grant_v) port_if.req_ready_o[grant_idx] = 1'b1;
        if (resp_ok) port_if.resp_v_o[head]         = 1'b1;
        port_if.mem_v_o     = grant_v;
        port_if.mem_w_o     = grant_v & port_if.req_w_i[grant_idx];
        port_if.mem_addr_o  = port_if.req_addr_i[int'(grant_idx)*paddr_width_p +: paddr_width_p];
        port_if.mem_data_o  = port_if.req_data_i[int'(grant_idx)*block_width_p +: block_width_p];
        port_if.mem_mask_o  = port_if.req_mask_i[int'(grant_idx)*mask_w_lp +: mask_w_lp];
        port_if.mem_yumi_o  = resp_ok & port_if.resp_yumi_i[head];
        port_if.resp_data_o = port_if.mem_data_i;
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) tags_q[wr_ptr_q] <= grant_idx;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && port_if.mem_v_i && (count_q == '0))
            $error("bp_mem_port_arbiter: memory response with no command outstanding");
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_bp_mem_port_arbiter
// Description : Directed plus random stimulus against a queue-based reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bp_mem_port_arbiter;
    localparam int N   = 2;
    localparam int PA  = 40;
    localparam int BW  = 512;
    localparam int MW  = BW / 8;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: issued-but-unanswered requester IDs in issue order.
    int   q[$];
    int   last = N - 1;

    always #5 clk = ~clk;

    bp_mem_port_arbiter_if #(.num_req_p(N), .paddr_width_p(PA), .block_width_p(BW)) bus ();

    bp_mem_port_arbiter #(
        .num_req_p(N), .paddr_width_p(PA), .block_width_p(BW), .max_outstanding_p(MAX)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .port_if (bus.slave)
    );

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] r;
        for (int j = 0; j < BW / 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.req_v_i     = '0;
        bus.req_w_i     = '0;
        bus.resp_yumi_i = '0;
        bus.mem_v_i     = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.mem_data_i  = rand_blk();
    endtask

    task automatic set_req(input int i, input logic w, input logic [PA-1:0] a,
                           input logic [BW-1:0] d, input logic [MW-1:0] m);
        bus.req_w_i[i]             = w;
        bus.req_addr_i[i*PA +: PA] = a;
        bus.req_data_i[i*BW +: BW] = d;
        bus.req_mask_i[i*MW +: MW] = m;
    endtask

    // Check outputs for the inputs currently applied, then advance the model one edge.
    task automatic cycle();
        logic [N-1:0] er, ev;
        int g, hd;
        logic ok, ey;
        #1;
        g = -1;
        if (!rst && bus.mem_ready_i && (q.size() < MAX)) begin
            for (int k = 1; k <= N; k++) begin
                int c;
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
                c = k - 1;
`else
                c = (last + k) % N;
`endif
                if (g < 0 && bus.req_v_i[c]) g = c;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", BW'(bus.req_ready_o), BW'(er));
        chk("mem_v", BW'(bus.mem_v_o), BW'(g >= 0));
        chk("mem_w", BW'(bus.mem_w_o), BW'((g >= 0) && bus.req_w_i[g]));
        if (g >= 0) begin
            chk("mem_addr", BW'(bus.mem_addr_o), BW'(bus.req_addr_i[g*PA +: PA]));
            chk("mem_data", bus.mem_data_o, bus.req_data_i[g*BW +: BW]);
            chk("mem_mask", BW'(bus.mem_mask_o), BW'(bus.req_mask_i[g*MW +: MW]));
        end
        ok = !rst && bus.mem_v_i && (q.size() > 0);
        hd = ok ? q[0] : 0;
        ev = '0;
        if (ok) ev[hd] = 1'b1;
        ey = ok && bus.resp_yumi_i[hd];
        chk("resp_v", BW'(bus.resp_v_o), BW'(ev));
        chk("mem_yumi", BW'(bus.mem_yumi_o), BW'(ey));
        chk("resp_data", bus.resp_data_o, bus.mem_data_i);
        @(posedge clk);
        if (rst) begin
            q.delete();
            last = N - 1;
        end else begin
            if (ey) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back(g);
                last = g;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_addr_i = '0;
        bus.req_data_i = '0;
        bus.req_mask_i = '0;
        idle();
        bus.req_v_i = '1;
        repeat (2) cycle();

        // Both requesters reading with memory ready: alternate until the FIFO fills.
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, PA'({$urandom, $urandom}), rand_blk(), '1);
        bus.req_v_i = 2'b11;
        repeat (6) cycle();

        // Full: no grant, pop does not bypass, grant resumes next cycle.
        bus.req_v_i = 2'b01;
        cycle();
        bus.mem_v_i     = 1'b1;
        bus.mem_data_i  = rand_blk();
        bus.resp_yumi_i = 2'b11;
        cycle();
        bus.mem_v_i = 1'b0;
        cycle();
        bus.req_v_i = '0;
        bus.mem_v_i = 1'b1;
        repeat (4) begin
            bus.mem_data_i = rand_blk();
            cycle();
        end

        // Write from requester 1 then read from requester 0; responses routed in order.
        idle();
        set_req(1, 1'b1, 40'h00_8000_0040, rand_blk(), '1);
        bus.req_v_i = 2'b10;
        cycle();
        set_req(0, 1'b0, 40'h00_8000_0000, rand_blk(), '0);
        bus.req_v_i = 2'b01;
        cycle();
        bus.req_v_i     = '0;
        bus.mem_v_i     = 1'b1;
        bus.resp_yumi_i = 2'b11;
        bus.mem_data_i  = rand_blk();
        cycle();
        bus.mem_data_i = rand_blk();
        cycle();

        // Yumi from the wrong requester is ignored.
        idle();
        bus.req_v_i = 2'b10;
        cycle();
        bus.req_v_i     = '0;
        bus.mem_v_i     = 1'b1;
        bus.resp_yumi_i = 2'b01;
        cycle();
        bus.resp_yumi_i = 2'b10;
        cycle();

        // Reset with commands in flight drops them; requester 0 wins first afterwards.
        idle();
        bus.req_v_i = 2'b11;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        for (int t = 0; t < 400; t++) begin
            rst             = ($urandom_range(99) == 0);
            bus.req_v_i     = N'($urandom);
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom), PA'({$urandom, $urandom}), rand_blk(), MW'({$urandom, $urandom}));
            bus.mem_ready_i = ($urandom_range(3) != 0);
            bus.mem_v_i     = (q.size() > 0) && ($urandom_range(1) == 1);
            bus.mem_data_i  = rand_blk();
            bus.resp_yumi_i = N'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
